fifo_ptr_ctrl: RTL and testbench
================================

FIFO_PTR_CTRL -- requirements
Module: fifo_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: FIFO depth is 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
REQ-002 SHALL have parameter SIDE, default 0: 0 = read side (pairs with the empty flag), 1 = write side (pairs with the full flag).
REQ-003 SHALL have port clk, input, 1 bit: local domain clock (clk_wr or clk_rd).
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port inc, input, 1 bit: push request (SIDE=1) or pop request (SIDE=0).
REQ-006 SHALL have port flag, input, 1 bit: full (SIDE=1) or empty (SIDE=0), from the flag stage.
REQ-007 SHALL have port ptr_rmt_async, input, ADDR_WIDTH+1 bits: remote-domain Gray pointer, asynchronous to clk.
REQ-008 SHALL have port accept, output, 1 bit: combinational inc & ~flag; RAM write/read strobe.
REQ-009 SHALL have port addr, output, ADDR_WIDTH bits: RAM address, equal to the low bits of the binary pointer.
REQ-010 SHALL have port ptr_gray, output, ADDR_WIDTH+1 bits: registered local Gray pointer, driving the flag stage and the remote domain.
REQ-011 SHALL have port ptr_rmt_sync, output, ADDR_WIDTH+1 bits: remote Gray pointer after the 2-flop synchronizer.
REQ-012 SHALL have port level, output, ADDR_WIDTH+1 bits: FIFO occupancy; present only under REQ-024.

Function
REQ-013 SHALL hold a binary pointer bin, ADDR_WIDTH+1 bits; bin_next = bin + accept, modulo 2^(ADDR_WIDTH+1).
REQ-014 SHALL register bin <= bin_next and ptr_gray <= bin_next ^ (bin_next >> 1) on the same edge, so ptr_gray always equals the Gray code of bin.
REQ-015 SHALL update addr and ptr_gray 1 cycle after an accepted inc.
REQ-016 SHALL leave bin, addr and ptr_gray unchanged when inc=1 and flag=1; accept SHALL be 0.
REQ-017 Wrap-around: bin SHALL go from 2^(ADDR_WIDTH+1)-1 to 0; ptr_gray SHALL change exactly 1 bit per increment, including at wrap.
REQ-018 SHALL pass ptr_rmt_async through two flops (sync1 -> ptr_rmt_sync) with no logic between them; latency is 2 clk edges.
REQ-019 SHALL take flag as given and add no look-ahead; protection against overflow/underflow is the flag stage's responsibility.

Reset
REQ-020 While rst_n=0 at a clk edge, bin, ptr_gray, both sync flops and level SHALL be cleared to 0.
REQ-021 Reset mid-operation SHALL discard any in-flight increment; accept SHALL be 0 during reset.
REQ-022 After reset, addr=0, ptr_gray=0 and ptr_rmt_sync=0 SHALL hold until the first accept or remote change.

Configuration
REQ-023 Without FIFO_PTR_LEVEL_EN, the level port and all its logic SHALL be absent.
REQ-024 With FIFO_PTR_LEVEL_EN, the block SHALL convert ptr_rmt_sync from Gray to binary (rbin) and register the level.
REQ-025 Under REQ-024, level SHALL be bin - rbin (SIDE=1) or rbin - bin (SIDE=0), modulo 2^(ADDR_WIDTH+1).
REQ-026 Under REQ-024, level SHALL be registered 1 cycle after bin or ptr_rmt_sync changes.

Structure
REQ-027 The shared package fifo_pkg SHALL hold the SIDE_RD=0 and SIDE_WR=1 constants and the bin2gray/gray2bin functions.
REQ-028 The 2-flop synchronizer SHALL be the sub-module sync_2ff, parameterized by width.

Verification (ADDR_WIDTH=4)
REQ-029 Reset: assert rst_n=0 for 2 cycles -> addr=0, ptr_gray=00000, ptr_rmt_sync=00000, level=0.
REQ-030 Increments: 3 cycles with inc=1, flag=0 -> addr=3, ptr_gray=00010 one cycle after the 3rd inc; accept=1 on each of those cycles.
REQ-031 Blocked: inc=1, flag=1 for 4 cycles -> accept=0; addr and ptr_gray unchanged.
REQ-032 Wrap: 31 accepts -> ptr_gray=10000; 32nd accept -> ptr_gray=00000 and addr=0; exactly 1 bit changes per step throughout.
REQ-033 Sync: ptr_rmt_async steps 00000 -> 00110 -> ptr_rmt_sync=00110 exactly 2 edges later.
REQ-034 Level (SIDE=1, macro on): bin=5 and ptr_rmt_async=00011 settled -> level=3; bin=1 with rbin=30 -> level=3 (wrap case).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and pointer-code helpers for the async FIFO pointer controllers.
// Helpers work on 32-bit values; callers zero-extend and truncate to their pointer width.
package fifo_pkg;

  localparam int SIDE_RD = 0;
  localparam int SIDE_WR = 1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper zero bits leave the result of a narrower pointer unaffected.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a Gray-coded bus; latency 2 clk edges, no backpressure.
// No logic sits between the two stages so the first flop has a full cycle to settle.
module sync_2ff #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
    end
  end

  assign q = sync2_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One-side pointer controller of an async FIFO: binary/Gray pointer, remote pointer sync.
// Optional registered occupancy output when FIFO_PTR_LEVEL_EN is defined.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int SIDE       = SIDE_RD
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  flag,
  input  logic [ADDR_WIDTH:0]   ptr_rmt_async,
  output logic                  accept,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [ADDR_WIDTH:0]   ptr_gray,
  output logic [ADDR_WIDTH:0]   ptr_rmt_sync
`ifdef FIFO_PTR_LEVEL_EN
  ,
  output logic [ADDR_WIDTH:0]   level
`endif
);

  localparam int PW = ADDR_WIDTH + 1;

  if (SIDE != SIDE_RD && SIDE != SIDE_WR) begin : g_bad_side
    $error("fifo_ptr_ctrl: SIDE must be SIDE_RD or SIDE_WR");
  end

  logic [PW-1:0] bin_q, bin_d;
  logic [PW-1:0] gray_q, gray_d;

  // Gated by reset so no RAM strobe escapes while the pointer is being cleared.
  assign accept = inc & ~flag & rst_n;

  always_comb begin
    bin_d  = bin_q + {{ADDR_WIDTH{1'b0}}, accept};
    gray_d = PW'(bin2gray(32'(bin_d)));
  end

  // Gray is derived from bin_d, not bin_q, so both registers move on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
    end
  end

  assign addr     = bin_q[ADDR_WIDTH-1:0];
  assign ptr_gray = gray_q;

  sync_2ff #(
    .WIDTH (PW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ptr_rmt_async),
    .q     (ptr_rmt_sync)
  );

`ifdef FIFO_PTR_LEVEL_EN
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_q, level_d;

  always_comb begin
    rbin    = PW'(gray2bin(32'(ptr_rmt_sync)));
    level_d = (SIDE == SIDE_WR) ? (bin_q - rbin) : (rbin - bin_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl (ADDR_WIDTH=4, write side).
// Define FIFO_PTR_LEVEL_EN to also exercise the occupancy output.
module tb_fifo_ptr_ctrl;

  localparam int AW = 4;
  localparam int PW = AW + 1;

  logic          clk;
  logic          rst_n;
  logic          inc;
  logic          flag;
  logic [PW-1:0] ptr_rmt_async;
  logic          accept;
  logic [AW-1:0] addr;
  logic [PW-1:0] ptr_gray;
  logic [PW-1:0] ptr_rmt_sync;
`ifdef FIFO_PTR_LEVEL_EN
  logic [PW-1:0] level;
`endif

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (AW),
    .SIDE       (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (inc),
    .flag          (flag),
    .ptr_rmt_async (ptr_rmt_async),
    .accept        (accept),
    .addr          (addr),
    .ptr_gray      (ptr_gray),
    .ptr_rmt_sync  (ptr_rmt_sync)
`ifdef FIFO_PTR_LEVEL_EN
    ,
    .level         (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] gray;
    logic [PW-1:0] sync;
    logic [PW-1:0] level;
    int            flips;
    logic          chk_flips;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side model state
  logic [PW-1:0] m_bin;
  logic [PW-1:0] m_s1;
  logic [PW-1:0] m_s2;
  logic [PW-1:0] m_level;
  logic [PW-1:0] prev_gray;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] m_gray(input logic [PW-1:0] b);
    logic [PW-1:0] g;
    for (int i = 0; i < PW - 1; i++) g[i] = b[i] ^ b[i+1];
    g[PW-1] = b[PW-1];
    return g;
  endfunction

  function automatic logic [PW-1:0] m_ungray(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    logic          acc;
    acc = 1'b0;
    for (int i = PW - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // One clock: drive, check the combinational strobe, predict, clock, compare.
  task automatic cycle(input logic i_rst, input logic i_inc, input logic i_flag,
                       input logic [PW-1:0] i_rmt);
    logic exp_acc;
    exp_t e;
    exp_t got;
    rst_n = ~i_rst;
    inc = i_inc;
    flag = i_flag;
    ptr_rmt_async = i_rmt;
    #1;
    exp_acc = i_rst ? 1'b0 : (i_inc & ~i_flag);
    check("accept", 32'(accept), 32'(exp_acc));
    if (i_rst) begin
      m_bin = '0;
      m_s1 = '0;
      m_s2 = '0;
      m_level = '0;
    end else begin
      m_level = m_bin - m_ungray(m_s2);
      m_s2 = m_s1;
      m_s1 = i_rmt;
      m_bin = m_bin + PW'(exp_acc);
    end
    e.addr = m_bin[AW-1:0];
    e.gray = m_gray(m_bin);
    e.sync = m_s2;
    e.level = m_level;
    e.flips = exp_acc ? 1 : 0;
    e.chk_flips = ~i_rst;
    exp_q.push_back(e);
    prev_gray = ptr_gray;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check("addr", 32'(addr), 32'(got.addr));
    check("ptr_gray", 32'(ptr_gray), 32'(got.gray));
    check("ptr_rmt_sync", 32'(ptr_rmt_sync), 32'(got.sync));
`ifdef FIFO_PTR_LEVEL_EN
    check("level", 32'(level), 32'(got.level));
`endif
    if (got.chk_flips)
      check("gray_1bit", 32'($countones(ptr_gray ^ prev_gray)), 32'(got.flips));
  endtask

  initial begin
    m_bin = '0;
    m_s1 = '0;
    m_s2 = '0;
    m_level = '0;
    prev_gray = '0;

    // Reset with inc held high: no strobe, everything cleared
    cycle(1'b1, 1'b1, 1'b0, 5'b00000);
    cycle(1'b1, 1'b1, 1'b0, 5'b00000);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_gray", 32'(ptr_gray), 32'd0);
    check("rst_sync", 32'(ptr_rmt_sync), 32'd0);
`ifdef FIFO_PTR_LEVEL_EN
    check("rst_level", 32'(level), 32'd0);
`endif

    // Three accepted increments
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 5'b00000);
    check("inc3_addr", 32'(addr), 32'd3);
    check("inc3_gray", 32'(ptr_gray), 32'b00010);

    // Blocked by full flag
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 5'b00000);
    check("blk_addr", 32'(addr), 32'd3);
    check("blk_gray", 32'(ptr_gray), 32'b00010);

    // Full wrap from a clean reset
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 31; i++) cycle(1'b0, 1'b1, 1'b0, 5'b00000);
    check("wrap31_gray", 32'(ptr_gray), 32'b10000);
    cycle(1'b0, 1'b1, 1'b0, 5'b00000);
    check("wrap32_gray", 32'(ptr_gray), 32'b00000);
    check("wrap32_addr", 32'(addr), 32'd0);

    // Remote pointer synchronizer latency
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b0, 1'b0, 1'b0, 5'b00110);
    check("sync_1edge", 32'(ptr_rmt_sync), 32'b00000);
    cycle(1'b0, 1'b0, 1'b0, 5'b00110);
    check("sync_2edge", 32'(ptr_rmt_sync), 32'b00110);

`ifdef FIFO_PTR_LEVEL_EN
    // bin=5, remote Gray 00011 (binary 2) -> 3
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 5'b00011);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 5'b00011);
    check("level_5m2", 32'(level), 32'd3);
    // bin=1, remote binary 30 (Gray 10001) -> 3 modulo 32
    cycle(1'b1, 1'b0, 1'b0, 5'b00000);
    cycle(1'b0, 1'b1, 1'b0, 5'b10001);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 5'b10001);
    check("level_wrap", 32'(level), 32'd3);
`endif

    // Mixed random traffic, remote pointer walking a Gray sequence
    begin
      logic [PW-1:0] rb;
      rb = '0;
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 3) == 0) rb = rb + 1'b1;
        cycle(($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), m_gray(rb));
      end
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
